// File: rtl/multdiv_issue_if.sv
// Issue-side and multdiv-side signal bundle for the multiply/divide sequencer.
// The master modport is the surrounding pipeline and unit; the slave modport is the sequencer.
interface multdiv_issue_if;
  logic        issue_valid;
  logic        issue_is_div;
  logic [31:0] issue_a;
  logic [31:0] issue_b;
  logic [4:0]  issue_rd;
  logic        flush;
  logic [31:0] md_operandA;
  logic [31:0] md_operandB;
  logic        md_ctrl_MULT;
  logic        md_ctrl_DIV;
  logic [31:0] md_result;
  logic        md_exception;
  logic        md_resultRDY;
  logic        stall;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_exception;
  logic        err_timeout;

  modport master (
    output issue_valid, issue_is_div, issue_a, issue_b, issue_rd, flush,
    output md_result, md_exception, md_resultRDY,
    input  md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
    input  stall, wb_valid, wb_rd, wb_data, wb_exception, err_timeout
  );

  modport slave (
    input  issue_valid, issue_is_div, issue_a, issue_b, issue_rd, flush,
    input  md_result, md_exception, md_resultRDY,
    output md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
    output stall, wb_valid, wb_rd, wb_data, wb_exception, err_timeout
  );
endinterface

// File: rtl/multdiv_issue.sv
// Execute-stage sequencer for the iterative multdiv unit: one start strobe per
// MUL/DIV, pipeline stall until ready, then a single (possibly redirected) write-back beat.
module multdiv_issue #(
  parameter int unsigned MAX_CYCLES   = 64,
  parameter int unsigned RDY_MASK     = 1,
  parameter logic [4:0]  RSTATUS_REG  = 5'd30,
  parameter logic [31:0] MUL_EXC_CODE = 32'd4,
  parameter logic [31:0] DIV_EXC_CODE = 32'd5
) (
  input logic           clock,
  input logic           reset,
  multdiv_issue_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(MAX_CYCLES + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_WAIT, ST_DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       rd_q;
  logic             is_div_q;
  logic             rdy_ok_c;
  logic             last_cycle_c;

  // Ready pulses left over from a previous operation are filtered for RDY_MASK cycles.
  assign rdy_ok_c     = bus.md_resultRDY && (cnt >= CNT_W'(RDY_MASK));
  assign last_cycle_c = (cnt == CNT_W'(MAX_CYCLES - 1));

  assign bus.stall = ((state == ST_IDLE) && bus.issue_valid) ||
                     (state == ST_START) || (state == ST_WAIT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= ST_IDLE;
      cnt              <= '0;
      rd_q             <= '0;
      is_div_q         <= 1'b0;
      bus.md_operandA  <= '0;
      bus.md_operandB  <= '0;
      bus.md_ctrl_MULT <= 1'b0;
      bus.md_ctrl_DIV  <= 1'b0;
      bus.wb_valid     <= 1'b0;
      bus.wb_rd        <= '0;
      bus.wb_data      <= '0;
      bus.wb_exception <= 1'b0;
      bus.err_timeout  <= 1'b0;
    end else begin
      bus.md_ctrl_MULT <= 1'b0;
      bus.md_ctrl_DIV  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (bus.issue_valid) begin
            bus.md_operandA  <= bus.issue_a;
            bus.md_operandB  <= bus.issue_b;
            rd_q             <= bus.issue_rd;
            is_div_q         <= bus.issue_is_div;
            bus.md_ctrl_MULT <= !bus.issue_is_div;
            bus.md_ctrl_DIV  <= bus.issue_is_div;
            state            <= ST_START;
          end
        end
        ST_START: begin
          cnt   <= '0;
          state <= bus.flush ? ST_IDLE : ST_WAIT;
        end
        ST_WAIT: begin
          // Flush wins over a coincident ready; ready wins over timeout.
          if (bus.flush) begin
            state <= ST_IDLE;
          end else if (rdy_ok_c) begin
            bus.wb_valid <= 1'b1;
            if (bus.md_exception) begin
              bus.wb_rd        <= RSTATUS_REG;
              bus.wb_data      <= is_div_q ? DIV_EXC_CODE : MUL_EXC_CODE;
              bus.wb_exception <= 1'b1;
            end else begin
              bus.wb_rd        <= rd_q;
              bus.wb_data      <= bus.md_result;
              bus.wb_exception <= 1'b0;
            end
            state <= ST_DONE;
          end else if (last_cycle_c) begin
            bus.err_timeout <= 1'b1;
            state           <= ST_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          bus.wb_valid     <= 1'b0;
          bus.wb_rd        <= '0;
          bus.wb_data      <= '0;
          bus.wb_exception <= 1'b0;
          state            <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_multdiv_issue.sv
// Directed bench for multdiv_issue; the bench plays the role of the multdiv unit.
module tb_multdiv_issue;
  logic clock;
  logic reset;
  int   checks;
  int   errors;

  multdiv_issue_if bus ();

  multdiv_issue dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Presents one instruction in IDLE and returns one cycle after the accepting edge (START).
  task automatic accept(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input string tag);
    bus.issue_valid  = 1'b1;
    bus.issue_is_div = is_div;
    bus.issue_a      = a;
    bus.issue_b      = b;
    bus.issue_rd     = rd;
    #1;
    chk1({tag, "_stall_accept"}, bus.stall, 1'b1);
    tick();
    bus.issue_valid = 1'b0;
    chk1({tag, "_mult_strobe"}, bus.md_ctrl_MULT, !is_div);
    chk1({tag, "_div_strobe"}, bus.md_ctrl_DIV, is_div);
    chk32({tag, "_opA"}, bus.md_operandA, a);
    chk32({tag, "_opB"}, bus.md_operandB, b);
  endtask

  // Full operation; the unit answers as early as the mask allows.
  task automatic run_op(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] res, input logic exc,
                        input logic early_rdy, input logic [4:0] exp_rd,
                        input logic [31:0] exp_data, input logic exp_exc, input string tag);
    bus.md_result    = res;
    bus.md_exception = exc;
    bus.md_resultRDY = early_rdy;
    accept(is_div, a, b, rd, tag);
    chk1({tag, "_wbv_start"}, bus.wb_valid, 1'b0);
    tick();
    chk1({tag, "_strobe_once"}, bus.md_ctrl_MULT | bus.md_ctrl_DIV, 1'b0);
    chk1({tag, "_wbv_wait0"}, bus.wb_valid, 1'b0);
    chk1({tag, "_stall_wait"}, bus.stall, 1'b1);
    bus.md_resultRDY = 1'b1;
    tick();
    chk1({tag, "_wbv_wait1"}, bus.wb_valid, 1'b0);
    tick();
    bus.md_resultRDY = 1'b0;
    chk1({tag, "_wbv"}, bus.wb_valid, 1'b1);
    chk32({tag, "_wb_rd"}, 32'(bus.wb_rd), 32'(exp_rd));
    chk32({tag, "_wb_data"}, bus.wb_data, exp_data);
    chk1({tag, "_wb_exc"}, bus.wb_exception, exp_exc);
    chk1({tag, "_stall_done"}, bus.stall, 1'b0);
    tick();
    chk1({tag, "_wbv_after"}, bus.wb_valid, 1'b0);
    chk32({tag, "_wb_data_after"}, bus.wb_data, 32'd0);
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    reset            = 1'b1;
    bus.issue_valid  = 1'b0;
    bus.issue_is_div = 1'b0;
    bus.issue_a      = '0;
    bus.issue_b      = '0;
    bus.issue_rd     = '0;
    bus.flush        = 1'b0;
    bus.md_result    = '0;
    bus.md_exception = 1'b0;
    bus.md_resultRDY = 1'b0;
    tick();
    tick();
    chk1("rst_stall", bus.stall, 1'b0);
    chk1("rst_wbv", bus.wb_valid, 1'b0);
    chk1("rst_mult", bus.md_ctrl_MULT, 1'b0);
    chk1("rst_timeout", bus.err_timeout, 1'b0);
    chk32("rst_opA", bus.md_operandA, 32'd0);
    reset = 1'b0;
    tick();

    run_op(1'b0, 32'd7, 32'd6, 5'd5, 32'd42, 1'b0, 1'b0, 5'd5, 32'd42, 1'b0, "mul7x6");
    run_op(1'b0, 32'h4000_0000, 32'd4, 5'd9, 32'd0, 1'b1, 1'b0, 5'd30, 32'd4, 1'b1, "mul_ovf");
    run_op(1'b1, 32'd100, 32'd7, 5'd3, 32'd14, 1'b0, 1'b0, 5'd3, 32'd14, 1'b0, "div100_7");
    run_op(1'b1, 32'd5, 32'd0, 5'd3, 32'hDEAD_BEEF, 1'b1, 1'b0, 5'd30, 32'd5, 1'b1, "div_by0");
    run_op(1'b0, 32'd2, 32'd8, 5'd12, 32'd16, 1'b0, 1'b1, 5'd12, 32'd16, 1'b0, "stale_rdy");
    run_op(1'b0, 32'd1, 32'd1, 5'd0, 32'd1, 1'b0, 1'b0, 5'd0, 32'd1, 1'b0, "rd0");

    // Flush in the second WAIT cycle, coincident with an otherwise acceptable ready.
    bus.md_result = 32'd77;
    accept(1'b0, 32'd11, 32'd7, 5'd4, "flush");
    tick();
    tick();
    bus.flush        = 1'b1;
    bus.md_resultRDY = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk1("flush_wbv", bus.wb_valid, 1'b0);
    chk1("flush_stall", bus.stall, 1'b0);
    tick();
    bus.md_resultRDY = 1'b0;
    chk1("flush_wbv_late", bus.wb_valid, 1'b0);
    run_op(1'b0, 32'd3, 32'd3, 5'd6, 32'd9, 1'b0, 1'b0, 5'd6, 32'd9, 1'b0, "mul3x3");

    // Timeout: 64 WAIT cycles with no ready.
    accept(1'b1, 32'd9, 32'd2, 5'd7, "tmo");
    for (int i = 0; i < 64; i++) begin
      tick();
      chk1("tmo_wbv_wait", bus.wb_valid, 1'b0);
    end
    chk1("tmo_not_yet", bus.err_timeout, 1'b0);
    chk1("tmo_stall_last", bus.stall, 1'b1);
    tick();
    chk1("tmo_set", bus.err_timeout, 1'b1);
    chk1("tmo_stall_idle", bus.stall, 1'b0);
    chk1("tmo_wbv", bus.wb_valid, 1'b0);
    tick();
    chk1("tmo_sticky", bus.err_timeout, 1'b1);

    // Asynchronous reset mid-WAIT.
    accept(1'b0, 32'd5, 32'd5, 5'd8, "rst_mid");
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk1("midrst_stall", bus.stall, 1'b0);
    chk1("midrst_timeout", bus.err_timeout, 1'b0);
    chk32("midrst_opA", bus.md_operandA, 32'd0);
    chk32("midrst_opB", bus.md_operandB, 32'd0);
    chk1("midrst_wbv", bus.wb_valid, 1'b0);
    chk32("midrst_wbrd", 32'(bus.wb_rd), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    run_op(1'b1, 32'd20, 32'd4, 5'd2, 32'd5, 1'b0, 1'b0, 5'd2, 32'd5, 1'b0, "after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
